bnn_sequencer: RTL and testbench

BNN_SEQUENCER -- requirements
Module: bnn_sequencer

---
 rtl/bnn_pkg.sv | 22 ++
 rtl/bnn_watchdog.sv | 22 ++
 rtl/bnn_sequencer.sv | 69 ++++++
 tb/tb_bnn_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared state encoding and layer indices for the BNN inference sequencer
package bnn_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_L1    = 3'd2,
        ST_L2    = 3'd3,
        ST_L3    = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6,
        ST_RSVD  = 3'd7
    } state_e;
    localparam int LAYER1 = 0;
    localparam int LAYER2 = 1;
    localparam int LAYER3 = 2;
    localparam int NUM_LAYERS = 3;
    function automatic logic [NUM_LAYERS-1:0] layer_onehot(input state_e s);
        return s == ST_L1 ? 3'b001 << LAYER1 :
               s == ST_L2 ? 3'b001 << LAYER2 :
               s == ST_L3 ? 3'b001 << LAYER3 : 3'b000;
    endfunction
endpackage

// File: rtl/bnn_watchdog.sv
// bnn_watchdog: per-state cycle counter that flags expiry after TIMEOUT_CYCLES-1 counted cycles
module bnn_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign expired = cnt_q == W'(TIMEOUT_CYCLES - 1);
    // count while enabled, parking at the expiry value
    always_comb begin
        cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
    end
    // counter register
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
endmodule

// File: rtl/bnn_sequencer.sv
// bnn_sequencer: steps pixel load and three BNN layers, latches the class result, guards each wait with a watchdog
module bnn_sequencer
    import bnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int LAT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             load_done,
    input  logic [2:0]       layer_done,
    input  logic [3:0]       answer_in,
    output logic [2:0]       state,
    output logic [2:0]       layer_start,
    output logic [3:0]       answer_out,
    output logic             answer_valid,
    output logic             error,
    output logic             busy,
    output logic [LAT_W-1:0] latency
);
    state_e state_q, state_d;
    logic [2:0] layer_start_q, layer_start_d;
    logic [3:0] answer_q, answer_d;
    logic [LAT_W-1:0] latency_q, latency_d;
    logic wd_expired;
    bnn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .enable  (busy),
        .expired (wd_expired)
    );
    assign state        = state_q;
    assign layer_start  = layer_start_q;
    assign answer_out   = answer_q;
    assign answer_valid = state_q == ST_DONE;
    assign error        = state_q == ST_ERROR;
    assign busy         = state_q inside {ST_LOAD, ST_L1, ST_L2, ST_L3};
    assign latency      = latency_q;
    // next state: a done flag beats watchdog expiry; only the current layer's flag is looked at
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = mode ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_d = load_done ? ST_L1 : wd_expired ? ST_ERROR : ST_LOAD;
            ST_L1:    state_d = layer_done[LAYER1] ? ST_L2 : wd_expired ? ST_ERROR : ST_L1;
            ST_L2:    state_d = layer_done[LAYER2] ? ST_L3 : wd_expired ? ST_ERROR : ST_L2;
            ST_L3:    state_d = layer_done[LAYER3] ? ST_DONE : wd_expired ? ST_ERROR : ST_L3;
            ST_DONE:  state_d = mode ? ST_DONE : ST_IDLE;
            ST_ERROR: state_d = mode ? ST_ERROR : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end
    // start pulse, result capture and saturating latency, all derived from the transition
    always_comb begin
        layer_start_d = state_d != state_q ? layer_onehot(state_d) : 3'b000;
        answer_d = (state_q == ST_L3 && state_d == ST_DONE) ? answer_in : answer_q;
        latency_d = (state_q == ST_IDLE && state_d == ST_LOAD) ? '0 :
                    (busy && latency_q != {LAT_W{1'b1}}) ? latency_q + 1'b1 : latency_q;
    end
    // registers; reset drops any pending start pulse
    always_ff @(posedge clk) begin
        state_q       <= reset ? ST_IDLE : state_d;
        layer_start_q <= reset ? 3'b000 : layer_start_d;
        answer_q      <= reset ? 4'd0 : answer_d;
        latency_q     <= reset ? '0 : latency_d;
    end
endmodule

// File: tb/tb_bnn_sequencer.sv
// tb_bnn_sequencer: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_bnn_sequencer;
    localparam int TO = 16;
    localparam int LW = 5;
    localparam int LMAX = (1 << LW) - 1;
    logic clk = 1'b0;
    logic reset = 1'b1, mode = 1'b0, load_done = 1'b0;
    logic [2:0] layer_done = 3'b000;
    logic [3:0] answer_in = 4'd0;
    logic [2:0] state, layer_start;
    logic [3:0] answer_out;
    logic answer_valid, error, busy;
    logic [LW-1:0] latency;
    int checks = 0, errors = 0;
    int m_st = 0, m_wd = 0, m_lat = 0, m_aout = 0, m_ls = 0;
    int pulses[3];
    int visited[$];
    typedef struct {
        logic m; logic ld; logic [2:0] lyr; logic [3:0] ans;
        int st; int ls; int aout; int lat;
    } vec_t;
    vec_t tbl[13];
    always #5 clk = ~clk;
    bnn_sequencer #(.TIMEOUT_CYCLES(TO), .LAT_W(LW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .load_done(load_done),
        .layer_done(layer_done), .answer_in(answer_in), .state(state),
        .layer_start(layer_start), .answer_out(answer_out),
        .answer_valid(answer_valid), .error(error), .busy(busy), .latency(latency)
    );
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // phases: 0 idle, 1 load, 2..4 layers, 5 done, 6 error; phases 1..4 each wait on one flag
    task automatic model_update();
        int nst;
        bit waiting, flag;
        logic [3:0] flags;
        if (reset) begin
            m_st = 0; m_wd = 0; m_lat = 0; m_aout = 0; m_ls = 0;
            return;
        end
        flags = {layer_done, load_done};
        waiting = m_st >= 1 && m_st <= 4;
        nst = m_st;
        if (m_st == 0) nst = mode ? 1 : 0;
        else if (waiting) begin
            flag = flags[m_st - 1];
            nst = flag ? m_st + 1 : (m_wd == TO - 1) ? 6 : m_st;
        end else nst = mode ? m_st : 0;
        m_ls = (nst != m_st && nst >= 2 && nst <= 4) ? (1 << (nst - 2)) : 0;
        if (m_st == 0 && nst == 1) m_lat = 0;
        else if (waiting) m_lat = m_lat == LMAX ? LMAX : m_lat + 1;
        if (m_st == 4 && nst == 5) m_aout = answer_in;
        m_wd = nst != m_st ? 0 : waiting ? m_wd + 1 : m_wd;
        m_st = nst;
    endtask
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("state", state, m_st);
        chk("layer_start", layer_start, m_ls);
        chk("answer_out", answer_out, m_aout);
        chk("answer_valid", answer_valid, m_st == 5);
        chk("error", error, m_st == 6);
        chk("busy", busy, m_st >= 1 && m_st <= 4);
        chk("latency", latency, m_lat);
    endtask
    task automatic nstep();
        step();
        for (int b = 0; b < 3; b++) if (layer_start[b]) pulses[b]++;
        if (visited[$] != int'(state)) visited.push_back(int'(state));
    endtask
    task automatic do_reset();
        reset = 1'b1; mode = 1'b0; load_done = 1'b0; layer_done = 3'b000;
        step();
        reset = 1'b0;
    endtask
    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 4'd0, 1, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 3'b111, 4'd0, 1, 0, 0, 1};
        tbl[2]  = '{1'b0, 1'b1, 3'b000, 4'd0, 2, 1, 0, 2};
        tbl[3]  = '{1'b0, 1'b1, 3'b110, 4'd0, 2, 0, 0, 3};
        tbl[4]  = '{1'b0, 1'b0, 3'b001, 4'd0, 3, 2, 0, 4};
        tbl[5]  = '{1'b0, 1'b0, 3'b101, 4'd0, 3, 0, 0, 5};
        tbl[6]  = '{1'b0, 1'b0, 3'b010, 4'd0, 4, 4, 0, 6};
        tbl[7]  = '{1'b0, 1'b0, 3'b011, 4'd3, 4, 0, 0, 7};
        tbl[8]  = '{1'b0, 1'b0, 3'b100, 4'd9, 5, 0, 9, 8};
        tbl[9]  = '{1'b1, 1'b0, 3'b000, 4'd2, 5, 0, 9, 8};
        tbl[10] = '{1'b0, 1'b0, 3'b000, 4'd2, 0, 0, 9, 8};
        tbl[11] = '{1'b1, 1'b0, 3'b000, 4'd2, 1, 0, 9, 0};
        tbl[12] = '{1'b0, 1'b1, 3'b000, 4'd2, 2, 1, 9, 1};
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_state", state, 0);
        chk("reset_outputs", {layer_start, answer_out, answer_valid, error, busy}, 0);
        chk("reset_latency", latency, 0);
        for (int i = 0; i < 13; i++) begin
            mode = tbl[i].m; load_done = tbl[i].ld; layer_done = tbl[i].lyr; answer_in = tbl[i].ans;
            step();
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_start", i), layer_start, tbl[i].ls);
            chk($sformatf("tbl%0d_answer", i), answer_out, tbl[i].aout);
            chk($sformatf("tbl%0d_latency", i), latency, tbl[i].lat);
            chk($sformatf("tbl%0d_valid", i), answer_valid, tbl[i].st == 5);
        end
        // nominal run: 11 load cycles, 5 cycles per layer
        do_reset();
        pulses = '{0, 0, 0};
        visited = {0};
        mode = 1'b1; answer_in = 4'd7;
        nstep();
        repeat (10) nstep();
        load_done = 1'b1;
        nstep();
        load_done = 1'b0;
        for (int b = 0; b < 3; b++) begin
            repeat (4) nstep();
            layer_done = 3'(1 << b);
            nstep();
            layer_done = 3'b000;
        end
        chk("nom_state", state, 5);
        chk("nom_latency", latency, 26);
        chk("nom_answer", answer_out, 7);
        chk("nom_valid", answer_valid, 1);
        for (int b = 0; b < 3; b++) chk($sformatf("nom_pulses%0d", b), pulses[b], 1);
        chk("nom_visited_len", visited.size(), 6);
        for (int k = 0; k < visited.size() && k < 6; k++) chk($sformatf("nom_visit%0d", k), visited[k], k);
        // back-to-back: old answer holds until the next capture
        mode = 1'b0;
        step();
        chk("b2b_idle_answer", answer_out, 7);
        mode = 1'b1; answer_in = 4'd3;
        step();
        chk("b2b_latency_restart", latency, 0);
        load_done = 1'b1; step(); load_done = 1'b0;
        layer_done = 3'b001; step();
        layer_done = 3'b010; step();
        chk("b2b_hold_answer", answer_out, 7);
        layer_done = 3'b100; step();
        layer_done = 3'b000;
        chk("b2b_new_answer", answer_out, 3);
        chk("b2b_latency", latency, 4);
        // timeout while holding in L2
        mode = 1'b0; step();
        mode = 1'b1; step();
        load_done = 1'b1; step(); load_done = 1'b0;
        layer_done = 3'b001; step(); layer_done = 3'b000;
        begin
            int n = 0;
            while (state != 3'd6 && n < 40) begin
                step();
                n++;
            end
            chk("timeout_cycles", n, 16);
        end
        chk("timeout_error", error, 1);
        mode = 1'b0; step();
        chk("timeout_release_state", state, 0);
        chk("timeout_release_error", error, 0);
        // done flag on the expiry cycle wins
        mode = 1'b1; step();
        load_done = 1'b1; step(); load_done = 1'b0;
        layer_done = 3'b001; step(); layer_done = 3'b000;
        repeat (15) step();
        layer_done = 3'b010; step(); layer_done = 3'b000;
        chk("tie_state", state, 4);
        chk("tie_error", error, 0);
        // reset in the middle of L2
        do_reset();
        mode = 1'b1; step();
        load_done = 1'b1; step(); load_done = 1'b0;
        layer_done = 3'b001; step(); layer_done = 3'b000;
        step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_mid_state", state, 0);
        chk("rst_mid_start", layer_start, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", answer_valid, 0);
        chk("rst_mid_latency", latency, 0);
        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset = $urandom_range(0, 299) == 0;
            mode = $urandom_range(0, 2) != 0;
            load_done = $urandom_range(0, 5) == 0;
            layer_done = {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0};
            answer_in = 4'($urandom);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
